// File: rtl/lbp_scan_ctrl.sv
// Raster-scan sequencer for the LBP engine: fetches each interior pixel's 3x3 window
// (full 9-fetch fill at row start, 3-fetch column refill after a shift) and pulses one write per pixel.
module lbp_scan_ctrl #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  output logic          win_load,
  output logic [3:0]    win_idx,
  output logic          win_shift,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic          finish
);

  typedef enum logic [2:0] {IDLE, ROWFILL, SHIFT, COLFILL, WRITE, DONE} state_t;

  localparam logic [AW-1:0] ROW   = AW'(IMG_W);
  localparam logic [AW-1:0] XLAST = AW'(IMG_W - 2);
  localparam logic [AW-1:0] YLAST = AW'(IMG_H - 2);

  state_t        state, state_n;
  logic [AW-1:0] x, x_n, y, y_n;
  logic [AW-1:0] top, top_n;   // (y-1)*IMG_W, advanced by +IMG_W per row
  logic [AW-1:0] ptr, ptr_n;   // address of the next gray fetch
  logic [1:0]    r, r_n, c, c_n;
  logic          fetch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x     <= AW'(1);
      y     <= AW'(1);
      top   <= '0;
      ptr   <= '0;
      r     <= '0;
      c     <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      top   <= top_n;
      ptr   <= ptr_n;
      r     <= r_n;
      c     <= c_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    top_n   = top;
    ptr_n   = ptr;
    r_n     = r;
    c_n     = c;
    fetch   = (state == ROWFILL || state == COLFILL) && gray_ready;
    case (state)
      IDLE: if (gray_ready) state_n = ROWFILL;
      ROWFILL, COLFILL: begin
        if (gray_ready) begin
          // Walk down a column, then hop to the top of the next one.
          if (r == 2'd2) begin
            r_n   = '0;
            c_n   = c + 2'd1;
            ptr_n = ptr - ROW - ROW + AW'(1);
            if (state == COLFILL || c == 2'd2) state_n = WRITE;
          end else begin
            r_n   = r + 2'd1;
            ptr_n = ptr + ROW;
          end
        end
      end
      SHIFT: begin
        r_n     = '0;
        c_n     = 2'd2;
        state_n = COLFILL;
      end
      WRITE: begin
        if (x < XLAST) begin
          x_n     = x + AW'(1);
          state_n = SHIFT;
        end else if (y < YLAST) begin
          y_n     = y + AW'(1);
          x_n     = AW'(1);
          top_n   = top + ROW;
          ptr_n   = top + ROW;
          r_n     = '0;
          c_n     = '0;
          state_n = ROWFILL;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  assign gray_req  = fetch;
  assign win_load  = fetch;
  assign gray_addr = fetch ? ptr : '0;
  assign win_idx   = fetch ? (4'({r, 1'b0}) + 4'(r) + 4'(c)) : 4'd0;
  assign win_shift = (state == SHIFT);
  assign lbp_valid = (state == WRITE);
  assign lbp_addr  = lbp_valid ? (top + ROW + x) : '0;
  assign finish    = (state == DONE);

endmodule
